// File: rtl/wb_arb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   XLEN    data width of a writeback
//   REG_AW  register address width (32 architectural registers)
//   TAG_W   program-order age tag width; tags wrap modulo 2^TAG_W
//   CNT_W   width of the same-destination conflict counter
//   wb_req_t   one writeback request as seen by the arbiter
//   tag_older  wrap-aware age compare between two tags
package wb_arb_pkg;

   localparam int XLEN   = 64;
   localparam int REG_AW = 5;
   localparam int TAG_W  = 4;
   localparam int CNT_W  = 16;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
      logic [TAG_W-1:0]  tag;
   } wb_req_t;

   // a is older than b when (a - b) mod 2^TAG_W lands in the upper half of
   // the tag space. Live tags must stay within half the space of each other.
   function automatic logic tag_older(input logic [TAG_W-1:0] a,
                                      input logic [TAG_W-1:0] b);
      logic [TAG_W-1:0] diff;
      diff = a - b;
      return diff[TAG_W-1];
   endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick2.sv
// Round-robin picker that selects up to two requesters per cycle.
//   elig      in   NREQ   requesters allowed to be granted this cycle
//   rr_ptr    in   PTR_W  index where the scan starts
//   slot1_oh  out  NREQ   one-hot first pick (all zero if none)
//   slot2_oh  out  NREQ   one-hot second pick (all zero if none)
//   next_ptr  out  PTR_W  one past the last pick, or rr_ptr if nothing picked
module rr_pick2 #(
   parameter int NREQ  = 3,
   parameter int PTR_W = 2
) (
   input  logic [NREQ-1:0]  elig,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [NREQ-1:0]  slot1_oh,
   output logic [NREQ-1:0]  slot2_oh,
   output logic [PTR_W-1:0] next_ptr
);

   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

   int               pos;
   logic [PTR_W-1:0] idx;
   logic [PTR_W-1:0] last;
   logic [1:0]       found;

   always_comb begin
      slot1_oh = '0;
      slot2_oh = '0;
      last     = '0;
      found    = 2'd0;
      pos      = 0;
      idx      = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = int'(rr_ptr) + k;
         if (pos >= NREQ) begin
            pos = pos - NREQ;
         end
         idx = PTR_W'(pos);
         if (elig[idx]) begin
            if (found == 2'd0) begin
               slot1_oh[idx] = 1'b1;
               last          = idx;
               found         = 2'd1;
            end else if (found == 2'd1) begin
               slot2_oh[idx] = 1'b1;
               last          = idx;
               found         = 2'd2;
            end
         end
      end

      if (found == 2'd0) begin
         next_ptr = rr_ptr;
      end else if (last == LAST_IDX) begin
         next_ptr = '0;
      end else begin
         next_ptr = last + 1'b1;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback scheduler for the dual-write-port register file.
// Shares the two register file write ports among NREQ writeback sources,
// never writes the same register twice in one cycle, and retires writes to
// the same register in program (tag) order.
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            per-requester handshake; transfer on valid&ready
//   req_rd/req_data/req_tag        packed per-requester destination, data, age tag
//   Wen1/Rd_addr1/write_data1      register file port 1, registered
//   Wen2/Rd_addr2/write_data2      register file port 2, registered
//   conflict_cnt                   saturating count of cycles with a held-back request
// XLEN and TAG_W must match the package, since requests travel as wb_req_t.
module wb_port_arbiter #(
   parameter int XLEN  = wb_arb_pkg::XLEN,
   parameter int NREQ  = 3,
   parameter int TAG_W = wb_arb_pkg::TAG_W,
   parameter int CNT_W = wb_arb_pkg::CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*5-1:0]     req_rd,
   input  logic [NREQ*XLEN-1:0]  req_data,
   input  logic [NREQ*TAG_W-1:0] req_tag,
   output logic                  Wen1,
   output logic [4:0]            Rd_addr1,
   output logic [XLEN-1:0]       write_data1,
   output logic                  Wen2,
   output logic [4:0]            Rd_addr2,
   output logic [XLEN-1:0]       write_data2,
   output logic [CNT_W-1:0]      conflict_cnt
);

   import wb_arb_pkg::*;

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   wb_req_t          req [NREQ];
   logic [NREQ-1:0]  elig;
   logic [NREQ-1:0]  pick_elig;
   logic             conflict;
   logic [NREQ-1:0]  slot1_oh;
   logic [NREQ-1:0]  slot2_oh;
   logic [PTR_W-1:0] next_ptr;

   logic [4:0]       s1_rd;
   logic [XLEN-1:0]  s1_data;
   logic [4:0]       s2_rd;
   logic [XLEN-1:0]  s2_data;

   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             wen1_q, wen1_d;
   logic [4:0]       addr1_q, addr1_d;
   logic [XLEN-1:0]  data1_q, data1_d;
   logic             wen2_q, wen2_d;
   logic [4:0]       addr2_q, addr2_d;
   logic [XLEN-1:0]  data2_q, data2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req[i].rd   = req_rd[5*i +: 5];
         req[i].data = req_data[XLEN*i +: XLEN];
         req[i].tag  = req_tag[TAG_W*i +: TAG_W];
      end
   end

   // A request is held back while an older valid request targets the same
   // nonzero register; x0 writes are discarded so they never need ordering.
   always_comb begin
      elig = req_valid;
      for (int i = 0; i < NREQ; i++) begin
         for (int j = 0; j < NREQ; j++) begin
            if (j != i && req_valid[j] && req[i].rd != '0 &&
                req[j].rd == req[i].rd &&
                (tag_older(req[j].tag, req[i].tag) ||
                 (req[j].tag == req[i].tag && j < i))) begin
               elig[i] = 1'b0;
            end
         end
      end
      conflict = |(req_valid & ~elig);
   end

   assign pick_elig = rst ? '0 : elig;

   rr_pick2 #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .elig     (pick_elig),
      .rr_ptr   (rr_ptr_q),
      .slot1_oh (slot1_oh),
      .slot2_oh (slot2_oh),
      .next_ptr (next_ptr)
   );

   assign req_ready = slot1_oh | slot2_oh;

   always_comb begin
      s1_rd   = '0;
      s1_data = '0;
      s2_rd   = '0;
      s2_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (slot1_oh[i]) begin
            s1_rd   = s1_rd | req[i].rd;
            s1_data = s1_data | req[i].data;
         end
         if (slot2_oh[i]) begin
            s2_rd   = s2_rd | req[i].rd;
            s2_data = s2_data | req[i].data;
         end
      end
   end

   always_comb begin
      rr_ptr_d = next_ptr;
      wen1_d   = 1'b0;
      addr1_d  = addr1_q;
      data1_d  = data1_q;
      wen2_d   = 1'b0;
      addr2_d  = addr2_q;
      data2_d  = data2_q;
      cnt_d    = cnt_q;

      // An x0 grant still consumes the slot and updates addr/data, but never
      // raises the write enable.
      if (|slot1_oh) begin
         wen1_d  = (s1_rd != '0);
         addr1_d = s1_rd;
         data1_d = s1_data;
      end
      if (|slot2_oh) begin
         wen2_d  = (s2_rd != '0);
         addr2_d = s2_rd;
         data2_d = s2_data;
      end

      if (conflict && cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
         wen1_q   <= 1'b0;
         addr1_q  <= '0;
         data1_q  <= '0;
         wen2_q   <= 1'b0;
         addr2_q  <= '0;
         data2_q  <= '0;
         cnt_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         wen1_q   <= wen1_d;
         addr1_q  <= addr1_d;
         data1_q  <= data1_d;
         wen2_q   <= wen2_d;
         addr2_q  <= addr2_d;
         data2_q  <= data2_d;
         cnt_q    <= cnt_d;
      end
   end

   assign Wen1         = wen1_q;
   assign Rd_addr1     = addr1_q;
   assign write_data1  = data1_q;
   assign Wen2         = wen2_q;
   assign Rd_addr2     = addr2_q;
   assign write_data2  = data2_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

   localparam int NREQ = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*5-1:0] req_rd;
   logic [NREQ*64-1:0] req_data;
   logic [NREQ*4-1:0] req_tag;
   logic              Wen1, Wen2;
   logic [4:0]        Rd_addr1, Rd_addr2;
   logic [63:0]       write_data1, write_data2;
   logic [15:0]       conflict_cnt;

   wb_port_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_rd       (req_rd),
      .req_data     (req_data),
      .req_tag      (req_tag),
      .Wen1         (Wen1),
      .Rd_addr1     (Rd_addr1),
      .write_data1  (write_data1),
      .Wen2         (Wen2),
      .Rd_addr2     (Rd_addr2),
      .write_data2  (write_data2),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wen1;
      logic [4:0]  a1;
      logic [63:0] d1;
      logic        wen2;
      logic [4:0]  a2;
      logic [63:0] d2;
      logic [15:0] cnt;
   } exp_t;

   exp_t expq[$];

   // requester state, held stable until granted
   logic [NREQ-1:0] pv;
   logic [4:0]      prd   [NREQ];
   logic [63:0]     pdata [NREQ];
   logic [3:0]      ptag  [NREQ];
   logic [3:0]      tag_ctr;

   // reference model state
   int          m_ptr;
   int          m_cnt;
   logic [4:0]  m_a1, m_a2;
   logic [63:0] m_d1, m_d2;

   logic [63:0] rf [32];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic bit m_older(input int j, input int i);
      logic [3:0] d;
      d = ptag[j] - ptag[i];
      return (d >= 4'd8) || (ptag[j] == ptag[i] && j < i);
   endfunction

   task automatic put(input int i, input logic [4:0] rd, input logic [63:0] data,
                      input logic [3:0] tag);
      pv[i]    = 1'b1;
      prd[i]   = rd;
      pdata[i] = data;
      ptag[i]  = tag;
   endtask

   // One clock cycle: drive requesters, predict the grant and the registered
   // port values, compare ready, then retire granted requests after the edge.
   task automatic step(input bit do_rst);
      logic [NREQ-1:0] el;
      logic [NREQ-1:0] rdy;
      int              g[$];
      exp_t            e;
      rst       = do_rst;
      req_valid = pv;
      for (int i = 0; i < NREQ; i++) begin
         req_rd[5*i +: 5]    = prd[i];
         req_data[64*i +: 64] = pdata[i];
         req_tag[4*i +: 4]   = ptag[i];
      end
      #2;
      el  = '0;
      rdy = '0;
      if (do_rst) begin
         m_ptr = 0;
         m_cnt = 0;
         m_a1 = '0; m_d1 = '0; m_a2 = '0; m_d2 = '0;
         e.wen1 = 1'b0;
         e.wen2 = 1'b0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (pv[i]) begin
               el[i] = 1'b1;
               if (prd[i] != 5'd0) begin
                  for (int j = 0; j < NREQ; j++) begin
                     if (j != i && pv[j] && prd[j] == prd[i] && m_older(j, i))
                        el[i] = 1'b0;
                  end
               end
            end
         end
         if ((pv & ~el) != '0 && m_cnt < 65535) m_cnt++;
         for (int k = 0; k < NREQ; k++) begin
            if (el[(m_ptr + k) % NREQ] && g.size() < 2) g.push_back((m_ptr + k) % NREQ);
         end
         foreach (g[n]) rdy[g[n]] = 1'b1;
         e.wen1 = 1'b0;
         e.wen2 = 1'b0;
         if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % NREQ;
         if (g.size() >= 1) begin
            e.wen1 = (prd[g[0]] != 5'd0);
            m_a1 = prd[g[0]];
            m_d1 = pdata[g[0]];
         end
         if (g.size() >= 2) begin
            e.wen2 = (prd[g[1]] != 5'd0);
            m_a2 = prd[g[1]];
            m_d2 = pdata[g[1]];
         end
      end
      e.a1  = m_a1;
      e.d1  = m_d1;
      e.a2  = m_a2;
      e.d2  = m_d2;
      e.cnt = 16'(m_cnt);
      chk("ready", {61'd0, req_ready}, {61'd0, rdy});
      expq.push_back(e);
      @(posedge clk);
      #1;
      pv = pv & ~rdy;
   endtask

   // Output monitor: pops the prediction for each registered cycle and
   // mirrors the register file from the DUT's write ports.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("wen1",  {63'd0, Wen1}, {63'd0, e.wen1});
            chk("addr1", {59'd0, Rd_addr1}, {59'd0, e.a1});
            chk("data1", write_data1, e.d1);
            chk("wen2",  {63'd0, Wen2}, {63'd0, e.wen2});
            chk("addr2", {59'd0, Rd_addr2}, {59'd0, e.a2});
            chk("data2", write_data2, e.d2);
            chk("cnt",   {48'd0, conflict_cnt}, {48'd0, e.cnt});
            if (Wen1) rf[Rd_addr1] = write_data1;
            if (Wen2) rf[Rd_addr2] = write_data2;
         end
      end
   end

   initial begin
      for (int r = 0; r < 32; r++) rf[r] = '0;
      tag_ctr = '0;
      m_ptr = 0; m_cnt = 0;
      m_a1 = '0; m_d1 = '0; m_a2 = '0; m_d2 = '0;
      rst = 1'b1;
      req_valid = '0; req_rd = '0; req_data = '0; req_tag = '0;
      pv = '0;
      put(0, 5'd1, 64'h1, 4'd0);
      put(1, 5'd2, 64'h2, 4'd1);
      put(2, 5'd3, 64'h3, 4'd2);
      @(posedge clk);
      #1;

      // reset held two cycles with every requester valid
      step(1'b1);
      step(1'b1);
      pv = '0;

      // two disjoint writes
      put(0, 5'd5, 64'h11, 4'd0);
      put(1, 5'd9, 64'h22, 4'd1);
      step(1'b0);

      // same rd=7, req1 older
      put(0, 5'd7, 64'hA0, 4'd3);
      put(1, 5'd7, 64'hB1, 4'd2);
      step(1'b0);
      step(1'b0);
      step(1'b0);
      #1;
      chk("rf_x7_last", rf[7], 64'hA0);
      chk("cnt_same_rd", {48'd0, conflict_cnt}, 64'd1);

      // tag wrap: 15 is older than 0
      put(0, 5'd4, 64'hC0, 4'd15);
      put(2, 5'd4, 64'hC2, 4'd0);
      step(1'b0);
      step(1'b0);
      step(1'b0);
      #1;
      chk("rf_x4_wrap", rf[4], 64'hC2);

      // three disjoint requests from a fresh pointer, then random traffic
      step(1'b1);
      put(0, 5'd1, 64'h101, 4'd0);
      put(1, 5'd2, 64'h102, 4'd0);
      put(2, 5'd3, 64'h103, 4'd0);
      step(1'b0);
      step(1'b0);
      chk("three_drained", {61'd0, pv}, 64'd0);
      tag_ctr = 4'd1;
      for (int c = 0; c < 30; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pv[i] && $urandom_range(0, 9) < 7)
               put(i, 5'($urandom_range(0, 7)), {$urandom, $urandom}, tag_ctr);
         end
         tag_ctr = tag_ctr + 4'd1;
         step(1'b0);
      end
      for (int c = 0; c < 10; c++) step(1'b0);
      chk("random_drained", {61'd0, pv}, 64'd0);

      // rd=0 alone, then three rd=0 at once
      put(0, 5'd0, 64'hDD, 4'd0);
      step(1'b0);
      put(0, 5'd0, 64'hE0, 4'd1);
      put(1, 5'd0, 64'hE1, 4'd1);
      put(2, 5'd0, 64'hE2, 4'd1);
      step(1'b0);
      chk("rd0_third_waits", {61'd0, pv}, 64'd1);
      step(1'b0);

      // reset in the middle of a burst
      put(0, 5'd10, 64'hF0, 4'd2);
      put(1, 5'd11, 64'hF1, 4'd2);
      step(1'b0);
      put(0, 5'd12, 64'hF2, 4'd3);
      step(1'b1);
      put(1, 5'd13, 64'hF3, 4'd3);
      put(2, 5'd14, 64'hF4, 4'd3);
      step(1'b0);
      step(1'b0);
      step(1'b0);

      @(posedge clk);
      #2;
      chk("queue_empty", 64'(expq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
